// File: rtl/regfile_decoded_pkg.sv
// rtl/regfile_decoded_pkg.sv - shared widths and types for the register file
package regfile_decoded_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int ZERO_REG = 31;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regnum_t;
endpackage

// File: rtl/regfile_decoded_if.sv
// rtl/regfile_decoded_if.sv - write port and two read ports of the register file
interface regfile_decoded_if;
    import regfile_decoded_pkg::*;

    logic    RegWrite;
    regnum_t WriteRegister;
    word_t   WriteData;
    regnum_t ReadRegister1;
    regnum_t ReadRegister2;
    word_t   ReadData1;
    word_t   ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_decoded_decoder.sv
// rtl/regfile_decoded_decoder.sv - 5:32 one-hot write-enable decode
module decoder5_32
    import regfile_decoded_pkg::*;
(
    input  regnum_t             in_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] out_o
);
    logic [3:0] bank;
    logic [7:0] lo;

    // 2:4 stage on the upper bits selects which 3:8 group is live.
    always_comb begin
        bank = '0;
        if (en_i) begin
            bank[in_i[4:3]] = 1'b1;
        end
        lo = 8'b1 << in_i[2:0];
        out_o = '0;
        for (int g = 0; g < 4; g++) begin
            out_o[8*g +: 8] = bank[g] ? lo : 8'h00;
        end
    end
endmodule

// File: rtl/regfile_decoded_mux.sv
// rtl/regfile_decoded_mux.sv - 32:1 word-wide read multiplexer
module mux32_1
    import regfile_decoded_pkg::*;
(
    input  word_t   d_i [NUM_REGS],
    input  regnum_t sel_i,
    output word_t   q_o
);
    assign q_o = d_i[sel_i];
endmodule

// File: rtl/regfile_decoded.sv
// rtl/regfile_decoded.sv - 32x64 register file, X31 hardwired to zero
module regfile_decoded
    import regfile_decoded_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    regfile_decoded_if.slave bus
);
    logic [NUM_REGS-1:0] en;
    word_t               regs_q [ZERO_REG];
    word_t               regs_d [ZERO_REG];
    word_t               rd_src [NUM_REGS];
    logic                unused_zero_en;

    decoder5_32 u_dec (
        .in_i  (bus.WriteRegister),
        .en_i  (bus.RegWrite),
        .out_o (en)
    );

    // X31 has no storage, so its enable line goes nowhere.
    assign unused_zero_en = en[ZERO_REG];

    always_comb begin
        for (int i = 0; i < ZERO_REG; i++) begin
            regs_d[i] = en[i] ? bus.WriteData : regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ZERO_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ZERO_REG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ZERO_REG; i++) begin
            rd_src[i] = regs_q[i];
        end
        rd_src[ZERO_REG] = '0;
    end

    mux32_1 u_rd1 (
        .d_i   (rd_src),
        .sel_i (bus.ReadRegister1),
        .q_o   (bus.ReadData1)
    );

    mux32_1 u_rd2 (
        .d_i   (rd_src),
        .sel_i (bus.ReadRegister2),
        .q_o   (bus.ReadData2)
    );
endmodule

// File: tb/tb_regfile_decoded.sv
// tb/tb_regfile_decoded.sv - directed and random checks of regfile_decoded
module tb_regfile_decoded;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [63:0] mdl [32];
    localparam logic [63:0] PAT = 64'h0101_0101_0101_0101;

    regfile_decoded_if bus ();

    regfile_decoded dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #100 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mdl_rd(input int a);
        return (a == 31) ? 64'h0 : mdl[a];
    endfunction

    // Update the reference with what is being presented, then cross the edge.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 64'h0;
        end else if (bus.RegWrite === 1'b1 && bus.WriteRegister != 5'd31) begin
            mdl[bus.WriteRegister] = bus.WriteData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = a[4:0];
        bus.WriteData     = d;
        tick();
        bus.RegWrite      = 1'b0;
    endtask

    task automatic rd(input int a1, input int a2);
        bus.ReadRegister1 = a1[4:0];
        bus.ReadRegister2 = a2[4:0];
        #50;
    endtask

    initial begin
        reset = 1'b1;
        bus.RegWrite = 1'b0;
        bus.WriteRegister = '0;
        bus.WriteData = '0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        rd(17, 31);
        chk("post_reset_rd1", bus.ReadData1, 64'h0);
        chk("post_reset_rd2", bus.ReadData2, 64'h0);

        // Reset wins over a same-cycle write.
        wr(5, 64'hDEAD_BEEF_0000_0001);
        rd(5, 5);
        chk("preload_x5", bus.ReadData1, 64'hDEAD_BEEF_0000_0001);
        reset = 1'b1;
        bus.RegWrite = 1'b1;
        bus.WriteRegister = 5'd5;
        bus.WriteData = 64'h1111_2222_3333_4444;
        tick();
        reset = 1'b0;
        bus.RegWrite = 1'b0;
        rd(5, 0);
        chk("reset_x5", bus.ReadData1, 64'h0);
        chk("reset_x0", bus.ReadData2, 64'h0);

        for (int i = 0; i < 31; i++) begin
            wr(i, PAT * 64'(i));
            rd(i, i);
            chk($sformatf("sweep_rd1_x%0d", i), bus.ReadData1, PAT * 64'(i));
            chk($sformatf("sweep_rd2_x%0d", i), bus.ReadData2, PAT * 64'(i));
            rd((i > 0) ? i - 1 : 0, i + 1);
            chk($sformatf("sweep_lo_x%0d", i), bus.ReadData1, (i > 0) ? PAT * 64'(i - 1) : 64'h0);
            chk($sformatf("sweep_hi_x%0d", i), bus.ReadData2, 64'h0);
        end

        wr(31, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(31, 31);
        chk("xzr_rd1", bus.ReadData1, 64'h0);
        chk("xzr_rd2", bus.ReadData2, 64'h0);
        for (int j = 0; j < 31; j++) begin
            rd(j, 30 - j);
            chk($sformatf("xzr_keep_x%0d", j), bus.ReadData1, PAT * 64'(j));
        end

        wr(7, 64'hAAAA);
        bus.RegWrite = 1'b0;
        bus.WriteRegister = 5'd7;
        bus.WriteData = 64'h1234;
        tick();
        rd(7, 7);
        chk("we0_x7", bus.ReadData1, 64'hAAAA);
        bus.WriteRegister = 'x;
        bus.WriteData = 'x;
        tick();
        rd(7, 8);
        chk("we0_xbus_x7", bus.ReadData1, 64'hAAAA);
        chk("we0_xbus_x8", bus.ReadData2, PAT * 64'd8);

        // No forwarding: old value before the edge, new value after it.
        wr(9, 64'h1);
        rd(9, 9);
        bus.RegWrite = 1'b1;
        bus.WriteRegister = 5'd9;
        bus.WriteData = 64'h2;
        #50;
        chk("rw_before_edge", bus.ReadData1, 64'h1);
        tick();
        bus.RegWrite = 1'b0;
        #49;
        chk("rw_after_edge", bus.ReadData1, 64'h2);

        wr(3, 64'h55);
        wr(12, 64'hCC);
        rd(3, 12);
        chk("dual_rd1", bus.ReadData1, 64'h55);
        chk("dual_rd2", bus.ReadData2, 64'hCC);
        rd(12, 12);
        chk("same_rd1", bus.ReadData1, 64'hCC);
        chk("same_rd2", bus.ReadData2, 64'hCC);

        for (int c = 0; c < 400; c++) begin
            int a1;
            int a2;
            reset = ($urandom_range(0, 39) == 0);
            bus.RegWrite = 1'($urandom_range(0, 1));
            bus.WriteRegister = 5'($urandom_range(0, 31));
            bus.WriteData = {$urandom, $urandom};
            a1 = $urandom_range(0, 31);
            a2 = (c % 4 == 0) ? a1 : int'($urandom_range(0, 31));
            rd(a1, a2);
            chk($sformatf("rand%0d_rd1_x%0d", c, a1), bus.ReadData1, mdl_rd(a1));
            chk($sformatf("rand%0d_rd2_x%0d", c, a2), bus.ReadData2, mdl_rd(a2));
            tick();
        end
        reset = 1'b0;
        bus.RegWrite = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rd(k, 31 - k);
            chk($sformatf("final_x%0d", k), bus.ReadData1, mdl_rd(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
